// File: rtl/execute_bru_agu_pkg.sv
// Shared execute-stage definitions for the branch/address generation unit:
// command encodings and pipeline occupancy states.
package execute_bru_agu_pkg;

    typedef enum logic [1:0] {
        BAGU_RLT = 2'd0,
        BAGU_IMM = 2'd1,
        BAGU_REG = 2'd2,
        BAGU_SEQ = 2'd3
    } bagu_cmd_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int TAG_W = 8;

endpackage

// File: rtl/execute_bru_agu_calc.sv
// Combinational branch target / fall-through computation.
// Optional target alignment check enabled by BRU_AGU_MISALIGN_CHECK_EN.
module execute_bru_agu_calc
    import execute_bru_agu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMM_W      = 26,
    parameter int OFS_W      = 16,
    parameter int DELAY_SLOT = 1
) (
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  src0_value,
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       bagu_cmd,
    input  logic [XLEN-1:0]  pred_target,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  wavefront,
    output logic             mispredict,
    output logic             misalign
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    bagu_cmd_e       cmd;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] rlt_ofs;
    logic            raw_mispredict;

    assign cmd       = bagu_cmd_e'(bagu_cmd);
    assign step      = pc + PC_INC;
    assign wavefront = (DELAY_SLOT != 0) ? step + PC_INC : step;
    // Word offset: sign-extended and scaled by 4
    assign rlt_ofs   = {{(XLEN-OFS_W-2){imm[OFS_W-1]}}, imm[OFS_W-1:0], 2'b00};

    always_comb begin
        target = wavefront;
        case (cmd)
            BAGU_RLT: target = step + rlt_ofs;
            BAGU_IMM: target = {step[XLEN-1:IMM_W+2], imm, 2'b00};
            BAGU_REG: target = src0_value;
            BAGU_SEQ: target = wavefront;
            default:  target = wavefront;
        endcase
    end

    assign raw_mispredict = (cmd != BAGU_SEQ) && (target != pred_target);

`ifdef BRU_AGU_MISALIGN_CHECK_EN
    // A misaligned register target traps instead of redirecting
    assign misalign   = (cmd == BAGU_REG) && (target[1:0] != 2'b00);
    assign mispredict = raw_mispredict && !misalign;
`else
    assign misalign   = 1'b0;
    assign mispredict = raw_mispredict;
`endif

endmodule

// File: rtl/execute_bru_agu_pipe.sv
// Branch/AGU execute stage: one registered output stage plus a one-entry skid
// buffer. Build option: BRU_AGU_MISALIGN_CHECK_EN (register target alignment check).
module execute_bru_agu_pipe
    import execute_bru_agu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMM_W      = 26,
    parameter int OFS_W      = 16,
    parameter int DELAY_SLOT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_src0_value,
    input  logic [IMM_W-1:0] i_imm,
    input  logic [1:0]       i_bagu_cmd,
    input  logic [XLEN-1:0]  i_pred_target,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_target,
    output logic [XLEN-1:0]  o_wavefront,
    output logic             o_mispredict,
    output logic             o_misalign,
    output logic [TAG_W-1:0] o_tag
);

    localparam int PW = 2*XLEN + 2 + TAG_W;

    pipe_state_e     state_reg, state_next;
    logic [PW-1:0]   out_reg, skid_reg, calc_payload;
    logic [XLEN-1:0] calc_target, calc_wavefront;
    logic            calc_mispredict, calc_misalign;
    logic            accept, drain;
    logic            load_out_in, load_out_skid, load_skid;

    execute_bru_agu_calc #(
        .XLEN       (XLEN),
        .IMM_W      (IMM_W),
        .OFS_W      (OFS_W),
        .DELAY_SLOT (DELAY_SLOT)
    ) u_calc (
        .pc          (i_pc),
        .src0_value  (i_src0_value),
        .imm         (i_imm),
        .bagu_cmd    (i_bagu_cmd),
        .pred_target (i_pred_target),
        .target      (calc_target),
        .wavefront   (calc_wavefront),
        .mispredict  (calc_mispredict),
        .misalign    (calc_misalign)
    );

    assign calc_payload = {calc_target, calc_wavefront, calc_mispredict, calc_misalign, i_tag};

    // Handshake flags decode straight from the state register
    assign o_ready = (state_reg != ST_SKID);
    assign o_valid = (state_reg != ST_EMPTY);
    assign accept  = i_valid && o_ready;
    assign drain   = o_valid && i_ready;

    always_comb begin
        state_next    = state_reg;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (i_flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next  = ST_FULL;
                        load_out_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_next = ST_SKID;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_next    = ST_FULL;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (load_out_in) begin
                out_reg <= calc_payload;
            end else if (load_out_skid) begin
                out_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= calc_payload;
            end
        end
    end

    assign {o_target, o_wavefront, o_mispredict, o_misalign, o_tag} = out_reg;

endmodule

// File: tb/tb_execute_bru_agu_pipe.sv
// Self-checking bench for execute_bru_agu_pipe: scoreboard of expected results
// built from an independent reference model, one task per scenario.
module tb_execute_bru_agu_pipe;

    typedef struct packed {
        logic [31:0] target;
        logic [31:0] wave;
        logic        mis;
        logic        mal;
        logic [7:0]  tag;
    } res_t;

    logic        clk = 1'b0;
    logic        reset, i_flush, i_valid, i_ready;
    logic        o_ready, o_valid, o_mispredict, o_misalign;
    logic [31:0] i_pc, i_src0_value, i_pred_target, o_target, o_wavefront;
    logic [25:0] i_imm;
    logic [1:0]  i_bagu_cmd;
    logic [7:0]  i_tag, o_tag;
    res_t        act;
    res_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    execute_bru_agu_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_pc          (i_pc),
        .i_src0_value  (i_src0_value),
        .i_imm         (i_imm),
        .i_bagu_cmd    (i_bagu_cmd),
        .i_pred_target (i_pred_target),
        .i_tag         (i_tag),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_target      (o_target),
        .o_wavefront   (o_wavefront),
        .o_mispredict  (o_mispredict),
        .o_misalign    (o_misalign),
        .o_tag         (o_tag)
    );

    always #5 clk = ~clk;

    assign act = {o_target, o_wavefront, o_mispredict, o_misalign, o_tag};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [1:0] cmd, input logic [31:0] pc, input logic [31:0] src,
                                   input logic [25:0] imm, input logic [31:0] pred, input logic [7:0] tag);
        res_t        r;
        logic [31:0] step, ofs;
        step   = pc + 32'd4;
        r.wave = pc + 32'd8;
        ofs    = {16'h0, imm[15:0]} * 32'd4;
        if (imm[15]) ofs = ofs - 32'h0004_0000;
        case (cmd)
            2'd0:    r.target = step + ofs;
            2'd1:    r.target = (step & 32'hF000_0000) | ({6'h0, imm} << 2);
            2'd2:    r.target = src;
            default: r.target = r.wave;
        endcase
        r.mis = (cmd != 2'd3) && (r.target != pred);
`ifdef BRU_AGU_MISALIGN_CHECK_EN
        r.mal = (cmd == 2'd2) && (r.target[1:0] != 2'b00);
        if (r.mal) r.mis = 1'b0;
`else
        r.mal = 1'b0;
`endif
        r.tag = tag;
        return r;
    endfunction

    function automatic res_t pop_exp();
        res_t r;
        r = 'x;
        if (q.size() != 0) r = q.pop_front();
        return r;
    endfunction

    task automatic drive(input logic [1:0] cmd, input logic [31:0] pc, input logic [31:0] src,
                         input logic [25:0] imm, input logic [31:0] pred, input logic [7:0] tag,
                         input bit push);
        i_valid       = 1'b1;
        i_bagu_cmd    = cmd;
        i_pc          = pc;
        i_src0_value  = src;
        i_imm         = imm;
        i_pred_target = pred;
        i_tag         = tag;
        if (push) q.push_back(model(cmd, pc, src, imm, pred, tag));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; tick(); tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || act !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b ready=%b out=%h required valid=0 ready=1 out=0", o_valid, o_ready, act);
        end
        reset = 1'b0; tick();
        i_ready = 1'b0;
        drive(2'd2, 32'h1234_5678, 32'hCAFE_0000, 26'h0, 32'h0, 8'h5A, 1'b0);
        tick(); i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload: got valid=%b required 1", o_valid);
        end
        reset = 1'b1; i_flush = 1'b1; tick();
        reset = 1'b0; i_flush = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || act !== '0) begin
            n_fail++;
            $display("FAIL reset_midop: got valid=%b ready=%b out=%h required valid=0 ready=1 out=0", o_valid, o_ready, act);
        end
        i_ready = 1'b1;
    endtask

    task automatic test_rlt();
        res_t e;
        drive(2'd0, 32'h0040_0000, 32'h0, 26'h000_FFFF, 32'h0040_0000, 8'h11, 1'b1);
        tick(); i_valid = 1'b0;
        e = pop_exp();
        n_checks++;
        if (o_valid !== 1'b1 || act !== e || o_target !== 32'h0040_0000 || o_wavefront !== 32'h0040_0008) begin
            n_fail++;
            $display("FAIL rlt: got valid=%b out=%h required valid=1 out=%h", o_valid, act, e);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rlt_drain: got valid=%b required 0", o_valid);
        end
    endtask

    task automatic test_imm();
        res_t e;
        drive(2'd1, 32'h1000_0000, 32'h0, 26'h010_0000, 32'h1040_0000, 8'h22, 1'b1);
        tick();
        e = pop_exp();
        n_checks++;
        if (o_valid !== 1'b1 || act !== e || o_target !== 32'h1040_0000 || o_mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_hit: got valid=%b out=%h required valid=1 out=%h", o_valid, act, e);
        end
        drive(2'd1, 32'h1000_0000, 32'h0, 26'h010_0000, 32'h1040_0004, 8'h23, 1'b1);
        tick(); i_valid = 1'b0;
        e = pop_exp();
        n_checks++;
        if (o_valid !== 1'b1 || act !== e || o_mispredict !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_miss: got valid=%b out=%h required valid=1 out=%h", o_valid, act, e);
        end
        tick();
    endtask

    task automatic test_reg_seq();
        res_t e;
        drive(2'd2, 32'h0000_1000, 32'h0040_0002, 26'h0, 32'h1234_5678, 8'h33, 1'b1);
        tick();
        e = pop_exp();
        n_checks++;
`ifdef BRU_AGU_MISALIGN_CHECK_EN
        if (o_valid !== 1'b1 || act !== e || o_misalign !== 1'b1 || o_mispredict !== 1'b0) begin
`else
        if (o_valid !== 1'b1 || act !== e || o_misalign !== 1'b0 || o_mispredict !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL reg_misalign: got out=%h required %h", act, e);
        end
        drive(2'd3, 32'h0000_2000, 32'h0, 26'h3FF_FFFF, 32'hDEAD_BEEC, 8'h34, 1'b1);
        tick(); i_valid = 1'b0;
        e = pop_exp();
        n_checks++;
        if (o_valid !== 1'b1 || act !== e || o_target !== 32'h0000_2008 || o_mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL seq: got out=%h required %h", act, e);
        end
        tick();
    endtask

    task automatic test_wrap();
        res_t e;
        drive(2'd0, 32'hFFFF_FFF8, 32'h0, 26'h000_0001, 32'h0, 8'h44, 1'b1);
        tick(); i_valid = 1'b0;
        e = pop_exp();
        n_checks++;
        if (o_valid !== 1'b1 || act !== e || o_target !== 32'h0 || o_wavefront !== 32'h0) begin
            n_fail++;
            $display("FAIL rlt_wrap: got out=%h required %h", act, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        res_t e;
        i_ready = 1'b0;
        drive(2'd0, 32'h0000_0100, 32'h0, 26'h000_0010, 32'h0, 8'hA1, 1'b1);
        tick();
        drive(2'd1, 32'h2000_0000, 32'h0, 26'h000_1234, 32'h0, 8'hB2, 1'b1);
        tick();
        n_checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1 || act !== q[0]) begin
            n_fail++;
            $display("FAIL b2b_skid: got ready=%b out=%h required ready=0 out=%h", o_ready, act, q[0]);
        end
        drive(2'd2, 32'h0, 32'h0000_C0C0, 26'h0, 32'h0000_C0C0, 8'hC3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || act !== q[0]) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: got ready=%b out=%h required ready=0 out=%h", i, o_ready, act, q[0]);
            end
        end
        i_ready = 1'b1;
        tick();
        void'(pop_exp());
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b1 || act !== q[0]) begin
            n_fail++;
            $display("FAIL b2b_release_b: got ready=%b out=%h required ready=1 out=%h", o_ready, act, q[0]);
        end
        q.push_back(model(2'd2, 32'h0, 32'h0000_C0C0, 26'h0, 32'h0000_C0C0, 8'hC3));
        tick(); i_valid = 1'b0;
        void'(pop_exp());
        e = pop_exp();
        n_checks++;
        if (o_valid !== 1'b1 || act !== e) begin
            n_fail++;
            $display("FAIL b2b_release_c: got valid=%b out=%h required %h", o_valid, act, e);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_empty: got valid=%b pending=%0d required valid=0 pending=0", o_valid, q.size());
        end
    endtask

    task automatic test_throughput();
        res_t e;
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(2'(i), $urandom, $urandom, 26'($urandom), $urandom, 8'(8'h60 + i), 1'b1);
            tick();
            e = pop_exp();
            n_checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b1 || act !== e) begin
                n_fail++;
                $display("FAIL stream%0d: got valid=%b ready=%b out=%h required %h", i, o_valid, o_ready, act, e);
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        res_t e;
        i_ready = 1'b0;
        drive(2'd0, 32'h0000_0800, 32'h0, 26'h000_0002, 32'h0, 8'hD1, 1'b1);
        tick();
        drive(2'd2, 32'h0, 32'h0000_4444, 26'h0, 32'h0, 8'hD2, 1'b1);
        tick();
        i_flush = 1'b1; i_ready = 1'b1;
        drive(2'd3, 32'h0000_9000, 32'h0, 26'h0, 32'h0, 8'hD3, 1'b0);
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        q.delete();
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: got valid=%b ready=%b required valid=0 ready=1", o_valid, o_ready);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stale: got valid=%b out=%h required valid=0", o_valid, act);
        end
        drive(2'd1, 32'hF000_0000, 32'h0, 26'h2AA_AAAA, 32'h0, 8'hD4, 1'b1);
        tick(); i_valid = 1'b0;
        e = pop_exp();
        n_checks++;
        if (o_valid !== 1'b1 || act !== e) begin
            n_fail++;
            $display("FAIL flush_recover: got valid=%b out=%h required %h", o_valid, act, e);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_pc = '0; i_src0_value = '0; i_imm = '0; i_bagu_cmd = '0; i_pred_target = '0; i_tag = '0;
        test_reset();
        test_rlt();
        test_imm();
        test_reg_seq();
        test_wrap();
        test_back_to_back();
        test_throughput();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_bru_agu_pipe.md
EXECUTE_BRU_AGU_PIPE -- requirements
Module: execute_bru_agu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/operand/target width (>= 32).
REQ-002 SHALL have parameter IMM_W, default 26, meaning jump-immediate field width.
REQ-003 SHALL have parameter OFS_W, default 16, meaning branch-offset field width (low OFS_W bits of i_imm).
REQ-004 SHALL have parameter DELAY_SLOT, default 1, meaning wavefront = PC+8 when 1, PC+4 when 0.
REQ-005 SHALL have ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- i_flush  in  1  discard pipeline contents
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_pc  in  XLEN  branch PC
- i_src0_value  in  XLEN  register target source
- i_imm  in  IMM_W  immediate field
- i_bagu_cmd  in  2  mode
- i_pred_target  in  XLEN  front-end predicted target
- i_tag  in  8  opaque ROB tag, passed through
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts when o_valid && i_ready
- o_target  out  XLEN  computed target
- o_wavefront  out  XLEN  fall-through PC
- o_mispredict  out  1  o_target != registered predicted target
- o_misalign  out  1  target misaligned (macro-gated)
- o_tag  out  8  tag of result

Function
REQ-006 SHALL compute step = PC + 4, with XLEN-bit wrap-around.
REQ-007 SHALL select the target by mode (XLEN arithmetic, carries discarded) as follows:
- BAGU_RLT = step + sign-extended {ofs, 2'b0}.
- BAGU_IMM = {step[XLEN-1:IMM_W+2], imm, 2'b0}.
- BAGU_REG = i_src0_value.
- BAGU_SEQ = wavefront (non-branch pass-through).
REQ-008 SHALL compute wavefront = PC + 8 if DELAY_SLOT else PC + 4, with wrap-around.
REQ-009 SHALL have latency of exactly 1 cycle: an input accepted at edge N SHALL be presented on the outputs with o_valid=1 after edge N.
REQ-010 SHALL form a single registered output stage plus a one-entry skid buffer, with o_ready registered (not combinationally dependent on i_ready).
REQ-011 SHALL hold o_ready=1 while the skid buffer is empty; when the output is stalled (o_valid && !i_ready) and a new input is accepted, that input SHALL enter the skid and o_ready SHALL drop the next cycle.
REQ-012 SHALL keep the output registers stable while o_valid && !i_ready.
REQ-013 SHALL advance the skid to the output on i_ready and reassert o_ready in the following cycle; ordering SHALL be strictly FIFO.
REQ-014 SHALL handle simultaneous accept and output-drain in the same cycle without bubble or loss, for full throughput of 1 result per cycle.
REQ-015 SHALL, on i_flush, clear o_valid and the skid next cycle, ignore any input presented that cycle, and take priority over all handshakes.
REQ-016 SHALL compute o_mispredict from the computed target against i_pred_target latched at accept; for BAGU_SEQ it SHALL be 0.
REQ-017 SHALL track three internal states: EMPTY (no result), FULL (output only), SKID (output and skid); EMPTY->FULL on accept; FULL->SKID on accept with stall; SKID->FULL on drain; FULL->EMPTY on drain without accept.

Reset
REQ-018 SHALL, on reset, set o_valid=0, o_ready=1, skid empty, and o_target, o_wavefront, o_tag, o_mispredict and o_misalign to 0.
REQ-019 SHALL discard any in-flight result when reset asserts mid-operation; reset SHALL have priority over i_flush.

Configuration
REQ-020 SHALL, with BRU_AGU_MISALIGN_CHECK_EN defined, set o_misalign = (target[1:0] != 0) for BAGU_REG and force o_mispredict=0 when o_misalign=1.
REQ-021 SHALL, without BRU_AGU_MISALIGN_CHECK_EN, tie o_misalign to 0, omit the check logic, and leave o_mispredict unchanged.

Structure
REQ-022 SHALL place BAGU_RLT=2'd0, BAGU_IMM=2'd1, BAGU_REG=2'd2 and BAGU_SEQ=2'd3 in the shared execute package.
REQ-023 SHALL implement the combinational address computation as sub-module execute_bru_agu_calc, with the handshake/skid logic in the top.

Verification
REQ-024 SHALL cover: RLT, pc=0x0040_0000, imm[15:0]=0xFFFF -> target 0x0040_0000, wavefront 0x0040_0008 one cycle later.
REQ-025 SHALL cover: IMM, pc=0x1000_0000, imm=0x010_0000 -> target 0x1040_0000; pred=0x1040_0000 -> o_mispredict=0.
REQ-026 SHALL cover: REG, src0=0x0040_0002, with macro -> o_misalign=1, o_mispredict=0; without macro -> o_misalign=0.
REQ-027 SHALL cover: back-to-back inputs A,B,C with i_ready=0 for 3 cycles -> A held, B in skid, o_ready=0, C not accepted; release -> A,B,C delivered in order.
REQ-028 SHALL cover: RLT wrap-around, pc=0xFFFF_FFF8, ofs=0x0001 -> target 0x0000_0000, wavefront 0x0000_0000.
REQ-029 SHALL cover: i_flush with SKID state plus a concurrent valid input -> next cycle o_valid=0, o_ready=1, no stale result emitted.
